instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program-counter owner and fetch sequencer sitting directly upstream of the byte-wide instruction ROM.
//  Drives the ROM byte address and reads one byte per cycle (ROM read is combinational).
//  Assembles four bytes little-endian into a 32-bit instruction and presents it to decode over a valid/ready handshake.
//  Handles sequential PC advance, redirect (branch/jump) flush, fetch halt and out-of-range fault tagging.
// PARAMETERS
//  ADDR_W     32          width of PC and ROM byte address
//  RESET_PC   32'h0       PC value loaded on reset
//  ROM_BYTES  1024        populated ROM size in bytes; fetches reaching beyond it are tagged faulty
// PORTS
//  clk            in   1       single clock; all state updates on rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  fetch_en       in   1       1 = fetch may advance; 0 = freeze byte sequencing
//  rom_addr       out  ADDR_W  byte address to ROM (combinational: pc + byte_cnt, mod 2^ADDR_W)
//  rom_data       in   8       ROM byte at rom_addr, valid in the same cycle
//  redirect_valid in   1       1 = load redirect_pc and flush
//  redirect_pc    in   ADDR_W  new PC; bits [1:0] forced to 0
//  if_valid       out  1       if_instr/if_pc/if_fault hold a valid instruction
//  if_ready       in   1       decode accepts when if_valid && if_ready
//  if_instr       out  32      {byte3,byte2,byte1,byte0}; byte0 at if_pc
//  if_pc          out  ADDR_W  address of byte0 of if_instr
//  if_fault       out  1       1 = any byte of this word lay at address >= ROM_BYTES
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): pc=RESET_PC, byte_cnt=0, asm_buf=0, fault_acc=0, if_valid=0, if_instr=0, if_pc=0, if_fault=0.
//  - State: pc, byte_cnt[1:0], asm_buf[23:0], fault_acc, and the output register (if_*).
//  - Per cycle, priority: redirect > byte sequencing; output handshake is evaluated independently.
//  - Redirect: pc<=redirect_pc&~3, byte_cnt<=0, asm_buf/fault_acc cleared, if_valid<=0. A word with if_valid&&if_ready in the same cycle counts as accepted; an unaccepted word is discarded.
//  - Output register is free when if_valid==0 or (if_valid && if_ready).
//  - Sequencing when fetch_en=1, no redirect:
//      byte_cnt 0..2: asm_buf[8*byte_cnt +: 8]<=rom_data; fault_acc|=(rom_addr>=ROM_BYTES); byte_cnt++.
//      byte_cnt 3, output free: if_instr<={rom_data,asm_buf}, if_pc<=pc, if_fault<=fault_acc|(rom_addr>=ROM_BYTES), if_valid<=1, pc<=pc+4 (wraps mod 2^ADDR_W), byte_cnt<=0, fault_acc<=0.
//      byte_cnt 3, output not free: stall; rom_addr stays pc+3, no state change.
//  - fetch_en=0: byte_cnt/pc/asm_buf hold; handshake still completes (if_valid<=0 on accept).
//  - Accept with no new load in that cycle: if_valid<=0; if_instr/if_pc/if_fault keep last values.
//  - Latency: first if_valid 4 cycles after reset release (fetch_en=1); sustained 1 instr / 4 cycles with if_ready=1.
//  - if_* stable while if_valid && !if_ready (no redirect).
//  - Fault tagging is informational; fetch continues past ROM_BYTES, reading whatever ROM returns.
//  - Address wrap: pc=2^ADDR_W-4 fetches 4 bytes, next pc=0; rom_addr never exceeds ADDR_W bits.
//  - Reset mid-word: partial bytes discarded, restart at RESET_PC byte 0.
// TESTING
//  - Reset, fetch_en=1, ready=1, ROM[0..3]=13,05,A0,00 -> cycle 4 if_valid=1, if_instr=32'h00A00513, if_pc=0; next word if_pc=4 four cycles later.
//  - Hold if_ready=0 after first word -> if_* stable; rom_addr stalls at 7; on ready=1 the next word (pc=4) appears the following cycle.
//  - Redirect to 32'h103 at byte_cnt=2 -> if_valid=0 next cycle, rom_addr=0x100, next if_pc=0x100 after 4 cycles.
//  - Redirect same cycle as valid&&ready -> word counted accepted, if_valid=0, fetch restarts at redirect target.
//  - Redirect to ROM_BYTES-2 (0x3FE -> 0x3FC) then 0x3FC..: word at 0x3FC if_fault=0, word at 0x400 if_fault=1.
//  - fetch_en=0 for 5 cycles at byte_cnt=1 then 1 -> rom_addr constant, word completes 3 cycles after re-enable; rst_n pulse mid-word -> restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the PC and walks a byte-wide combinational ROM four bytes
// per word. It assembles little-endian instructions into a valid/ready output register.
module instr_fetch_unit #(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter int unsigned         ROM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_fault
);
    localparam logic [ADDR_W:0] ROM_LIM = (ADDR_W+1)'(ROM_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       buf_q, buf_d;
    logic              facc_q, facc_d;
    logic              vld_q, vld_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              flt_q, flt_d;

    logic out_free, oob;

    assign rom_addr = pc_q + ADDR_W'(cnt_q);
    // Extra MSB keeps the range test correct when rom_addr sits near 2^ADDR_W.
    assign oob      = {1'b0, rom_addr} >= ROM_LIM;
    assign out_free = !vld_q || if_ready;

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        facc_d  = facc_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        flt_d   = flt_q;

        if (vld_q && if_ready) vld_d = 1'b0;

        if (redirect_valid) begin
            pc_d   = redirect_pc & ~ADDR_W'(3);
            cnt_d  = 2'd0;
            buf_d  = '0;
            facc_d = 1'b0;
            vld_d  = 1'b0;
        end else if (fetch_en) begin
            if (cnt_q != 2'd3) begin
                case (cnt_q)
                    2'd0:    buf_d[7:0]   = rom_data;
                    2'd1:    buf_d[15:8]  = rom_data;
                    default: buf_d[23:16] = rom_data;
                endcase
                facc_d = facc_q | oob;
                cnt_d  = cnt_q + 2'd1;
            end else if (out_free) begin
                // Last byte goes straight to the output; a full register stalls here.
                instr_d = {rom_data, buf_q};
                ipc_d   = pc_q;
                flt_d   = facc_q | oob;
                vld_d   = 1'b1;
                pc_d    = pc_q + ADDR_W'(4);
                cnt_d   = 2'd0;
                facc_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            buf_q   <= '0;
            facc_q  <= 1'b0;
            vld_q   <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            flt_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            facc_q  <= facc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            flt_q   <= flt_d;
        end
    end

    assign if_valid = vld_q;
    assign if_instr = instr_q;
    assign if_pc    = ipc_q;
    assign if_fault = flt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner sequences and random
// stimulus checked against a word-level reference model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] rom_addr;
    logic [7:0]  rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    int npass = 0;
    int ntot  = 0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .ROM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_fault(if_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] romb(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'hA0;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {romb(a + 32'd3), romb(a + 32'd2), romb(a + 32'd1), romb(a)};
    endfunction

    function automatic logic flt(input logic [31:0] a);
        logic f = 1'b0;
        for (int k = 0; k < 4; k++) if ((a + 32'(k)) >= 32'd1024) f = 1'b1;
        return f;
    endfunction

    assign rom_data = romb(rom_addr);

    // Reference model: a word is "bytes gathered so far" plus a PC; the completed word
    // is formed directly from the ROM contents at pc..pc+3.
    logic [31:0] m_pc, m_ipc, m_instr;
    int          m_n;
    logic        m_vld, m_fault;

    task automatic model_reset();
        m_pc = 32'h0; m_n = 0; m_vld = 1'b0; m_ipc = '0; m_instr = '0; m_fault = 1'b0;
    endtask

    task automatic model_next();
        logic free;
        free = !m_vld || if_ready;
        if (m_vld && if_ready) m_vld = 1'b0;
        if (redirect_valid) begin
            m_pc = {redirect_pc[31:2], 2'b00}; m_n = 0; m_vld = 1'b0;
        end else if (fetch_en) begin
            if (m_n < 3) m_n++;
            else if (free) begin
                m_ipc = m_pc; m_instr = word(m_pc); m_fault = flt(m_pc);
                m_vld = 1'b1; m_pc = m_pc + 32'd4; m_n = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_chk();
        chk("m_addr",  rom_addr, m_pc + 32'(m_n));
        chk("m_valid", 32'(if_valid), 32'(m_vld));
        chk("m_pc",    if_pc, m_ipc);
        chk("m_instr", if_instr, m_instr);
        chk("m_fault", 32'(if_fault), 32'(m_fault));
    endtask

    task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
        fetch_en = fe; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        model_next();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        model_chk();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    typedef struct {
        bit          fe, rdy, rv;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc, einstr, eaddr;
    } vec_t;

    function automatic vec_t mk(bit rdy, bit rv, logic [31:0] rpc, bit ev,
                                logic [31:0] epc, logic [31:0] einstr, logic [31:0] eaddr);
        vec_t v;
        v.fe = 1'b1; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr;
        return v;
    endfunction

    vec_t tv[21];

    initial begin
        tv[0]  = mk(1, 0, 0, 0, 0, 0, 32'd1);
        tv[1]  = mk(1, 0, 0, 0, 0, 0, 32'd2);
        tv[2]  = mk(1, 0, 0, 0, 0, 0, 32'd3);
        tv[3]  = mk(1, 0, 0, 1, 32'd0, 32'h00A00513, 32'd4);
        tv[4]  = mk(1, 0, 0, 0, 0, 0, 32'd5);
        tv[5]  = mk(1, 0, 0, 0, 0, 0, 32'd6);
        tv[6]  = mk(1, 0, 0, 0, 0, 0, 32'd7);
        tv[7]  = mk(1, 0, 0, 1, 32'd4, word(32'd4), 32'd8);
        tv[8]  = mk(0, 0, 0, 1, 32'd4, word(32'd4), 32'd9);
        tv[9]  = mk(0, 0, 0, 1, 32'd4, word(32'd4), 32'd10);
        tv[10] = mk(0, 0, 0, 1, 32'd4, word(32'd4), 32'd11);
        tv[11] = mk(0, 0, 0, 1, 32'd4, word(32'd4), 32'd11);
        tv[12] = mk(0, 0, 0, 1, 32'd4, word(32'd4), 32'd11);
        tv[13] = mk(1, 0, 0, 1, 32'd8, word(32'd8), 32'd12);
        tv[14] = mk(1, 0, 0, 0, 0, 0, 32'd13);
        tv[15] = mk(1, 0, 0, 0, 0, 0, 32'd14);
        tv[16] = mk(1, 1, 32'h103, 0, 0, 0, 32'h100);
        tv[17] = mk(1, 0, 0, 0, 0, 0, 32'h101);
        tv[18] = mk(1, 0, 0, 0, 0, 0, 32'h102);
        tv[19] = mk(1, 0, 0, 0, 0, 0, 32'h103);
        tv[20] = mk(1, 0, 0, 1, 32'h100, word(32'h100), 32'h104);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc",    if_pc, 32'd0);
        chk("rst_fault", 32'(if_fault), 32'd0);
        chk("rst_addr",  rom_addr, 32'd0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].fe, tv[i].rdy, tv[i].rv, tv[i].rpc);
            chk("tv_addr",  rom_addr, tv[i].eaddr);
            chk("tv_valid", 32'(if_valid), 32'(tv[i].ev));
            if (tv[i].ev) begin
                chk("tv_pc",    if_pc, tv[i].epc);
                chk("tv_instr", if_instr, tv[i].einstr);
            end
        end

        // Redirect in the same cycle the pending word is accepted.
        step(1, 1, 1, 32'h200);
        chk("rdacc_valid", 32'(if_valid), 32'd0);
        chk("rdacc_addr",  rom_addr, 32'h200);
        run(3);
        chk("rdacc_novld", 32'(if_valid), 32'd0);
        run(1);
        chk("rdacc_pc",    if_pc, 32'h200);
        chk("rdacc_instr", if_instr, word(32'h200));

        // ROM boundary fault tagging.
        step(1, 1, 1, 32'h3FE);
        chk("bnd_addr", rom_addr, 32'h3FC);
        run(4);
        chk("bnd_pc0",    if_pc, 32'h3FC);
        chk("bnd_fault0", 32'(if_fault), 32'd0);
        run(4);
        chk("bnd_pc1",    if_pc, 32'h400);
        chk("bnd_fault1", 32'(if_fault), 32'd1);

        // fetch_en low at byte_cnt=1 freezes the sequencer.
        step(1, 1, 1, 32'h40);
        step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            chk("frz_addr", rom_addr, 32'h41);
        end
        chk("frz_valid", 32'(if_valid), 32'd0);
        run(2);
        chk("frz_wait", 32'(if_valid), 32'd0);
        run(1);
        chk("frz_valid1", 32'(if_valid), 32'd1);
        chk("frz_pc",     if_pc, 32'h40);

        // Reset pulse mid-word.
        step(1, 1, 1, 32'h80);
        run(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_addr",  rom_addr, 32'd0);
        chk("mrst_valid", 32'(if_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        run(4);
        chk("mrst_pc",    if_pc, 32'd0);
        chk("mrst_instr", if_instr, 32'h00A00513);

        // PC wrap at the top of the address space.
        step(1, 1, 1, 32'hFFFF_FFFE);
        run(4);
        chk("wrap_pc",    if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", if_instr, word(32'hFFFF_FFFC));
        chk("wrap_fault", 32'(if_fault), 32'd1);
        chk("wrap_addr",  rom_addr, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tgt;
            bit          rv;
            rv = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = 32'($urandom_range(0, 32'h7FF));
                1:       tgt = 32'h3F0 + 32'($urandom_range(0, 31));
                default: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            endcase
            step($urandom_range(0, 4) != 0, $urandom_range(0, 9) < 6, rv, tgt);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
